// File: rtl/pitcher_multi.sv
// pitcher_multi: multi-channel timed pulse generator.
//
// Each channel turns a rising edge on its ask bit into a result pulse that is
// PULSE_TICKS ticks long. In blink mode the channel emits BLINKS on/off cycles
// instead. A single free-running prescaler divides clk down to the tick rate.
// Ticks are shared by all channels, so a pulse can last seconds.
//
// Optional feature macro: PITCHER_ASK_SYNC_EN
//   defined   : each ask bit passes a 2-FF synchroniser (ask may be async),
//               ask change -> result high takes 3 clk cycles.
//   undefined : ask must be synchronous to clk, ask change -> result high in
//               1 clk cycle.
//
// Ports:
//   clk     in   1   system clock
//   rst_n   in   1   asynchronous active-low reset
//   ask     in   CH  per-channel trigger, rising edge acts
//   retrig  in   1   1 = trigger during an active pulse restarts it (live)
//   blink   in   1   0 = single pulse, 1 = blink train (latched at trigger)
//   result  out  CH  registered pulse output, active high
//   busy    out  CH  channel is in ON or OFF

module pitcher_ch #(
    parameter int PULSE_TICKS = 2000,
    parameter int CNT_W       = 16,
    parameter int BLINKS      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic trig,
    input  logic retrig,
    input  logic blink,
    output logic result,
    output logic busy
);
    localparam int BW = $clog2(BLINKS + 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]    left_q, left_d;
    logic             mode_q, mode_d;
    logic             result_q, result_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        mode_d  = mode_q;
        // A restart has priority over a tick in the same cycle, so with
        // retrig set the pulse never drops even on its terminal tick.
        if (trig && (state_q == IDLE || retrig)) begin
            state_d = ON;
            cnt_d   = CNT_W'(PULSE_TICKS);
            left_d  = BW'(BLINKS);
            mode_d  = blink;
        end else if (tick && state_q != IDLE) begin
            if (cnt_q == CNT_W'(1)) begin
                if (state_q == ON) begin
                    if (!mode_q || left_q == BW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = OFF;
                        cnt_d   = CNT_W'(PULSE_TICKS);
                        left_d  = left_q - BW'(1);
                    end
                end else begin
                    state_d = ON;
                    cnt_d   = CNT_W'(PULSE_TICKS);
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        result_d = (state_d == ON);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            left_q   <= '0;
            mode_q   <= 1'b0;
            result_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
endmodule

module pitcher_multi #(
    parameter int CH          = 4,
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 1000,
    parameter int PULSE_TICKS = 2000,
    parameter int CNT_W       = 16,
    parameter int BLINKS      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] ask,
    input  logic          retrig,
    input  logic          blink,
    output logic [CH-1:0] result,
    output logic [CH-1:0] busy
);
    localparam int P  = CLK_HZ / TICK_HZ;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    if (PULSE_TICKS < 1) begin : g_err_pulse
        $error("pitcher_multi: PULSE_TICKS must be >= 1");
    end
    if (BLINKS < 1) begin : g_err_blinks
        $error("pitcher_multi: BLINKS must be >= 1");
    end
    if (P < 1) begin : g_err_presc
        $error("pitcher_multi: CLK_HZ must be >= TICK_HZ");
    end
    if ((longint'(PULSE_TICKS) >> CNT_W) != 0) begin : g_err_cnt
        $error("pitcher_multi: CNT_W too narrow for PULSE_TICKS");
    end

    logic [CH-1:0] ask_in;

`ifdef PITCHER_ASK_SYNC_EN
    // History becomes trustworthy one cycle after the synchroniser output does.
    localparam int STAGES = 3;
    logic [CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = ask;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign ask_in = sync2_q;
`else
    localparam int STAGES = 1;
    assign ask_in = ask;
`endif

    logic [PW-1:0]     presc_q, presc_d;
    logic [CH-1:0]     ask_prev_q, ask_prev_d;
    logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;
    logic              tick;
    logic              hist_ok;
    logic [CH-1:0]     trig;

    // tick marks the cycle whose closing edge wraps the prescaler to 0.
    assign tick    = (presc_q == PW'(P - 1));
    // Edge history is cleared by reset. An ask already high at release must
    // not look like a fresh edge, so edges are ignored until the history
    // holds a real sample.
    assign hist_ok = vld_pipe_q[STAGES-1];
    assign trig    = ask_in & ~ask_prev_q & {CH{hist_ok}};

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        ask_prev_d = ask_in;
        vld_pipe_d = (vld_pipe_q << 1) | STAGES'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            ask_prev_q <= '0;
            vld_pipe_q <= '0;
        end else begin
            presc_q    <= presc_d;
            ask_prev_q <= ask_prev_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        pitcher_ch #(
            .PULSE_TICKS(PULSE_TICKS),
            .CNT_W      (CNT_W),
            .BLINKS     (BLINKS)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .trig  (trig[g]),
            .retrig(retrig),
            .blink (blink),
            .result(result[g]),
            .busy  (busy[g])
        );
    end
endmodule
